// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-to-WB bundle (MEM result, load descriptor, stage
// controls, RAM read data) plus the register file write port.
// The master modport is the driving side (MEM stage / RAM / hazard unit);
// the slave modport is the WB stage itself.
// Optional trace signals are present only when WB_DEBUG_TRACE_EN is defined.
interface mem_wb_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_result;
    logic                  mem_load_en;
    logic [2:0]            mem_load_type;
    logic [1:0]            mem_addr_low;
    logic                  mem_stall;
    logic                  wb_stall;
    logic                  flush;
    logic [DATA_WIDTH-1:0] ram_read_data;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0]           mem_pc;
    logic [31:0]           debug_wb_pc;
    logic [3:0]            debug_wb_we;
    logic [4:0]            debug_wb_addr;
    logic [31:0]           debug_wb_data;
`else
    // trace signals are absent in this build
`endif

    modport master (
`ifdef WB_DEBUG_TRACE_EN
        output mem_pc,
        input  debug_wb_pc, debug_wb_we, debug_wb_addr, debug_wb_data,
`endif
        output mem_write_en, mem_write_addr, mem_result,
        output mem_load_en, mem_load_type, mem_addr_low,
        output mem_stall, wb_stall, flush, ram_read_data,
        input  write_en, write_addr, write_data
    );

    modport slave (
`ifdef WB_DEBUG_TRACE_EN
        input  mem_pc,
        output debug_wb_pc, debug_wb_we, debug_wb_addr, debug_wb_data,
`endif
        input  mem_write_en, mem_write_addr, mem_result,
        input  mem_load_en, mem_load_type, mem_addr_low,
        input  mem_stall, wb_stall, flush, ram_read_data,
        output write_en, write_addr, write_data
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and register-file writeback.
// Load data from the synchronous RAM arrives one cycle after the MEM-to-WB
// transfer; if WB is stalled in that cycle the raw word is parked in
// hold_data so it survives until the stall releases.
// Optional feature macro: WB_DEBUG_TRACE_EN (PC trace and debug write port).
module mem_wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
);

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;

    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_ALU        = 2'd1,
        ST_LOAD_FRESH = 2'd2,
        ST_LOAD_HELD  = 2'd3
    } state_t;

    state_t                  state_p1;
    state_t                  state_nxt;
    logic                    vld_p1;
    logic                    wen_p1;
    logic [ADDR_WIDTH-1:0]   addr_p1;
    logic [DATA_WIDTH-1:0]   result_p1;
    logic [2:0]              load_type_p1;
    logic [1:0]              addr_low_p1;
    logic [DATA_WIDTH-1:0]   hold_data_p1;
    logic                    capture;
    logic                    bubble;

    // Little-endian byte/halfword select with sign or zero extension;
    // unknown encodings fall through to a full word.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [2:0]            ltype,
        input logic [1:0]            alow
    );
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [DATA_WIDTH-1:0] ext;
        byte_s = raw[{alow, 3'b000} +: 8];
        half_s = alow[1] ? raw[31:16] : raw[15:0];
        case (ltype)
            LT_LB:   ext = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
            LT_LBU:  ext = {{(DATA_WIDTH-8){1'b0}}, byte_s};
            LT_LH:   ext = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
            LT_LHU:  ext = {{(DATA_WIDTH-16){1'b0}}, half_s};
            default: ext = raw;
        endcase
        return ext;
    endfunction

    // Decode what the MEM stage hands over at the next edge.
    always_comb begin
        capture = ~bus.flush & ~bus.wb_stall & ~bus.mem_stall;
        bubble  = bus.flush | (~bus.wb_stall & bus.mem_stall);
    end

    // ---- WB stage register (_p1) ----

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1 <= ST_EMPTY;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Next state: flush beats stall, a fresh load parks on stall.
    always_comb begin
        state_nxt = state_p1;
        if (bubble) begin
            state_nxt = ST_EMPTY;
        end else if (bus.wb_stall) begin
            if (state_p1 == ST_LOAD_FRESH) begin
                state_nxt = ST_LOAD_HELD;
            end
        end else if (capture) begin
            state_nxt = bus.mem_load_en ? ST_LOAD_FRESH : ST_ALU;
        end
    end

    // Instruction fields: captured on advance, valid dropped on bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1       <= 1'b0;
            wen_p1       <= 1'b0;
            addr_p1      <= '0;
            result_p1    <= '0;
            load_type_p1 <= '0;
            addr_low_p1  <= '0;
        end else if (bubble) begin
            vld_p1 <= 1'b0;
        end else if (capture) begin
            vld_p1       <= bus.mem_write_en | bus.mem_load_en;
            wen_p1       <= bus.mem_write_en;
            addr_p1      <= bus.mem_write_addr;
            result_p1    <= bus.mem_result;
            load_type_p1 <= bus.mem_load_type;
            addr_low_p1  <= bus.mem_addr_low;
        end
    end

    // Park the RAM word when a fresh load is stalled; it is gone next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data_p1 <= '0;
        end else if ((state_p1 == ST_LOAD_FRESH) && bus.wb_stall && !bus.flush) begin
            hold_data_p1 <= bus.ram_read_data;
        end
    end

    // Register file write port, combinational from state and registers.
    always_comb begin
        bus.write_en   = vld_p1 & wen_p1 & ~bus.wb_stall & (state_p1 != ST_EMPTY);
        bus.write_addr = addr_p1;
        case (state_p1)
            ST_LOAD_FRESH: bus.write_data = load_extend(bus.ram_read_data, load_type_p1, addr_low_p1);
            ST_LOAD_HELD:  bus.write_data = load_extend(hold_data_p1, load_type_p1, addr_low_p1);
            default:       bus.write_data = result_p1;
        endcase
    end

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] pc_p1;

    // PC travels with the instruction; bubbles leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_p1 <= '0;
        end else if (capture) begin
            pc_p1 <= bus.mem_pc;
        end
    end

    // Trace port mirrors the register file write.
    always_comb begin
        bus.debug_wb_pc   = pc_p1;
        bus.debug_wb_we   = {4{bus.write_en}};
        bus.debug_wb_addr = bus.write_addr[4:0];
        bus.debug_wb_data = bus.write_data;
    end
`else
    // no trace registers in this build
`endif

endmodule
